piezo_event_conditioner: RTL and testbench
==========================================

Name: piezo_event_conditioner

Overview:
- Sits directly upstream of the RTC event inputs (event_trigger, event_trigger2) in the SoC fabric.
- Takes two raw, asynchronous comparator outputs from the acoustic front-end and synchronises them.
- Glitch-filters each one and converts each qualified rising edge into a single-cycle event pulse with a per-channel hold-off window.
- Gates detection with the RTC's piezo_enable, so events are only reported while the transmit side has armed the receiver.

Parameters:
- SYNC_STAGES, 2, flip-flop depth of the input synchroniser (legal range 2-4).
- FILTER_CYCLES, 8, number of consecutive high samples required to qualify an edge (legal range 1-255).
- HOLDOFF_CYCLES, 50000, cycles after a fired event during which the channel ignores input (legal range 1 to 2^24-1).
- CNT_W, 16, width of the per-channel event counters.

Ports:
- clk  in  1  system clock (50 MHz)
- reset  in  1  asynchronous, active-high reset
- sensor_in  in  2  raw comparator outputs; asynchronous to clk
- piezo_enable  in  1  arm level from RTC; 1 = detection allowed
- clear_counts  in  1  single-cycle pulse that zeroes both event counters
- event_trigger  out  1  channel 0 event pulse to RTC
- event_trigger2  out  1  channel 1 event pulse to RTC
- event_count0  out  CNT_W  channel 0 fired-event count
- event_count1  out  CNT_W  channel 1 fired-event count
- ch_state  out  6  {ch1_state[2:0], ch0_state[2:0]}, debug view of each channel's state

Behaviour:
- Reset: all synchroniser flops = 0, all channels in DISARMED, event_trigger = event_trigger2 = 0, counters = 0, ch_state = 0.
- Synchroniser: sensor_in[i] passes through SYNC_STAGES flops, giving s[i]. All filtering below uses s[i].
- Per-channel FSM, one identical instance per channel. State encoding: DISARMED=0, WAIT_LOW=1, ARMED=2, FILTER=3, FIRE=4, HOLDOFF=5.
  - DISARMED: if piezo_enable = 1, go to WAIT_LOW.
  - WAIT_LOW: if s = 0, go to ARMED. This prevents a level that is already high at arm time from firing.
  - ARMED: if s = 1, go to FILTER and load the filter counter with 1.
  - FILTER: while s = 1, increment the filter counter. When the counter equals FILTER_CYCLES, go to FIRE. If s = 0 before that, return to ARMED.
  - FILTER_CYCLES = 1 has a special path: ARMED goes straight to FIRE on the first high sample.
  - FIRE: lasts exactly one cycle. The event output is 1 for that cycle. The count saturates at 2^CNT_W-1 and does not wrap. Next state is HOLDOFF, with the hold-off counter loaded to 0.
  - HOLDOFF: increment the hold-off counter. When it equals HOLDOFF_CYCLES-1, go to WAIT_LOW. Input is ignored throughout.
  - piezo_enable = 0 in any state except FIRE: go to DISARMED on the next clock. FIRE still completes its pulse and count, then goes to DISARMED instead of HOLDOFF.
- Event output is registered: it is high exactly during the cycle the FSM is in FIRE. It is never high for two consecutive cycles.
- Latency:
  - Sensor rising edge reaches s after SYNC_STAGES cycles.
  - The event pulse follows FILTER_CYCLES cycles after s first goes high.
  - Total at defaults: 2 + 8 = 10 cycles from the sampled edge to the pulse.
- Channels are fully independent. Simultaneous edges on both channels produce both pulses in the same cycle.
- clear_counts zeroes both counters on the next clock. If clear_counts coincides with FIRE, the clear wins and the counter reads 0.
- Asynchronous reset mid-operation aborts any pulse immediately: the output drops within the reset assertion, with no clock required.
- Counter widths: the filter counter is 8 bits and the hold-off counter is 24 bits. Parameter values outside the legal ranges are unsupported.

Test Plan:
1. Reset, then piezo_enable = 1. Drive sensor_in[0] high for 20 cycles starting at cycle 100. Expect one event_trigger pulse exactly 10 cycles after the sampled edge, event_count0 = 1, and event_trigger2 never asserted.
2. Glitch rejection: with the channel armed, apply a 7-cycle-high sensor_in[0] pulse. Expect no event and event_count0 = 0; ch_state[2:0] returns to 2.
3. Hold-off (HOLDOFF_CYCLES = 100): apply edges at t = 0, t = 50 and t = 200. Expect exactly 2 events, from the t = 0 and t = 200 edges; the t = 50 edge is ignored.
4. Arm with level high: sensor_in[1] = 1 before piezo_enable rises. Expect no event until sensor_in[1] falls and rises again, then one event_trigger2 pulse.
5. Simultaneous and clear: assert both sensors together. Expect event_trigger and event_trigger2 in the same cycle. Then pulse clear_counts in a FIRE cycle and expect both counts = 0.
6. Saturation (CNT_W = 2): fire 5 events. Expect event_count0 = 3 and no wrap. Assert reset during FILTER: all outputs = 0 asynchronously and ch_state = 0.

Source files
------------

// File: rtl/piezo_event_conditioner.sv
// Synchronises and glitch-filters two piezo comparator inputs into single-cycle RTC event pulses with per-channel hold-off.
// Latency: SYNC_STAGES + FILTER_CYCLES cycles from the sampled edge to the pulse; no backpressure, events are fire-and-forget.
module piezo_event_conditioner #(
  parameter int SYNC_STAGES    = 2,
  parameter int FILTER_CYCLES  = 8,
  parameter int HOLDOFF_CYCLES = 50000,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       sensor_in,
  input  logic             piezo_enable,
  input  logic             clear_counts,
  output logic             event_trigger,
  output logic             event_trigger2,
  output logic [CNT_W-1:0] event_count0,
  output logic [CNT_W-1:0] event_count1,
  output logic [5:0]       ch_state
);

  typedef enum logic [2:0] {
    DISARMED = 3'd0,
    WAIT_LOW = 3'd1,
    ARMED    = 3'd2,
    FILTER   = 3'd3,
    FIRE     = 3'd4,
    HOLDOFF  = 3'd5
  } ch_state_e;

  localparam logic [7:0]       FILT_LAST = 8'(FILTER_CYCLES - 1);
  localparam logic [23:0]      HOLD_LAST = 24'(HOLDOFF_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam bit               FAST_PATH = (FILTER_CYCLES == 1);

  logic [1:0]       ev_vec;
  logic [CNT_W-1:0] cnt_vec [2];
  logic [2:0]       st_vec  [2];

  genvar g;
  generate
    for (g = 0; g < 2; g++) begin : g_ch
      logic [SYNC_STAGES-1:0] sync_q;
      logic                   s;
      ch_state_e              state_q, state_d;
      logic [7:0]             filt_q, filt_d;
      logic [23:0]            hold_q, hold_d;
      logic [CNT_W-1:0]       count_q, count_d;
      logic                   event_q;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          sync_q <= '0;
        end else begin
          sync_q <= {sync_q[SYNC_STAGES-2:0], sensor_in[g]};
        end
      end

      assign s = sync_q[SYNC_STAGES-1];

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          state_q <= DISARMED;
          filt_q  <= '0;
          hold_q  <= '0;
          count_q <= '0;
          event_q <= 1'b0;
        end else begin
          state_q <= state_d;
          filt_q  <= filt_d;
          hold_q  <= hold_d;
          count_q <= count_d;
          event_q <= (state_d == FIRE);
        end
      end

      always_comb begin
        state_d = state_q;
        filt_d  = filt_q;
        hold_d  = hold_q;
        case (state_q)
          DISARMED: if (piezo_enable) state_d = WAIT_LOW;
          WAIT_LOW: if (!s) state_d = ARMED;
          ARMED: begin
            if (s) begin
              if (FAST_PATH) begin
                state_d = FIRE;
              end else begin
                state_d = FILTER;
                filt_d  = 8'd1;
              end
            end
          end
          FILTER: begin
            if (!s) begin
              state_d = ARMED;
            end else begin
              filt_d = filt_q + 8'd1;
              if (filt_q == FILT_LAST) state_d = FIRE;
            end
          end
          FIRE: begin
            state_d = HOLDOFF;
            hold_d  = '0;
          end
          HOLDOFF: begin
            if (hold_q == HOLD_LAST) state_d = WAIT_LOW;
            else                     hold_d  = hold_q + 24'd1;
          end
          default: state_d = DISARMED;
        endcase
        // FIRE's pulse and count are already committed, so disarming here is safe in every state
        if (!piezo_enable) state_d = DISARMED;
      end

      always_comb begin
        count_d = count_q;
        if (clear_counts) begin
          count_d = '0;
        end else if (state_q == FIRE && count_q != CNT_MAX) begin
          count_d = count_q + CNT_ONE;
        end
      end

      assign ev_vec[g]  = event_q;
      assign cnt_vec[g] = count_q;
      assign st_vec[g]  = state_q;
    end
  endgenerate

  assign event_trigger  = ev_vec[0];
  assign event_trigger2 = ev_vec[1];
  assign event_count0   = cnt_vec[0];
  assign event_count1   = cnt_vec[1];
  assign ch_state       = {st_vec[1], st_vec[0]};

endmodule

// File: tb/tb_piezo_event_conditioner.sv
// Directed bench: main instance (hold-off 100) plus a small instance (filter 1, hold-off 3, 2-bit counters).
module tb_piezo_event_conditioner;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]  sensor = 2'b00;
  logic        en = 1'b0;
  logic        clr = 1'b0;
  logic        ev0, ev1;
  logic [15:0] cnt0, cnt1;
  logic [5:0]  st;

  logic [1:0]  s_sensor = 2'b00;
  logic        s_en = 1'b0;
  logic        s_clr = 1'b0;
  logic        s_ev0, s_ev1;
  logic [1:0]  s_cnt0, s_cnt1;
  logic [5:0]  s_st;

  piezo_event_conditioner #(
    .SYNC_STAGES(2), .FILTER_CYCLES(8), .HOLDOFF_CYCLES(100), .CNT_W(16)
  ) dut (
    .clk(clk), .reset(reset), .sensor_in(sensor), .piezo_enable(en),
    .clear_counts(clr), .event_trigger(ev0), .event_trigger2(ev1),
    .event_count0(cnt0), .event_count1(cnt1), .ch_state(st)
  );

  piezo_event_conditioner #(
    .SYNC_STAGES(2), .FILTER_CYCLES(1), .HOLDOFF_CYCLES(3), .CNT_W(2)
  ) dut_sat (
    .clk(clk), .reset(reset), .sensor_in(s_sensor), .piezo_enable(s_en),
    .clear_counts(s_clr), .event_trigger(s_ev0), .event_trigger2(s_ev1),
    .event_count0(s_cnt0), .event_count1(s_cnt1), .ch_state(s_st)
  );

  int checks = 0;
  int errors = 0;

  // pulse counters sampled mid-cycle; dbl catches any pulse lasting two cycles
  int n_ev0 = 0, n_ev1 = 0, s_n_ev0 = 0, dbl = 0;
  logic p_ev0 = 1'b0, p_ev1 = 1'b0;
  always @(negedge clk) begin
    if (ev0) n_ev0++;
    if (ev1) n_ev1++;
    if (s_ev0) s_n_ev0++;
    if ((ev0 && p_ev0) || (ev1 && p_ev1)) dbl++;
    p_ev0 = ev0;
    p_ev1 = ev1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  int t_first, t_second, base;
  logic early;

  initial begin
    // reset state
    repeat (3) tick();
    chk("rst_ev", {30'd0, ev1, ev0}, 32'd0);
    chk("rst_cnt", {cnt1, cnt0}, 32'd0);
    chk("rst_state", {26'd0, st}, 32'd0);
    reset = 1'b0;
    s_en  = 1'b1;
    tick();
    chk("disarmed_hold", {26'd0, st}, 32'd0);

    // 1: single qualified edge on channel 0
    en = 1'b1;
    tick();
    tick();
    chk("t1_armed", {26'd0, st}, 32'd18);
    repeat (96) tick();
    sensor[0] = 1'b1;
    early = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      tick();
      if (ev0) early = 1'b1;
    end
    chk("t1_no_early", {31'd0, early}, 32'd0);
    tick();
    chk("t1_pulse", {30'd0, ev1, ev0}, 32'd1);
    tick();
    chk("t1_single", {31'd0, ev0}, 32'd0);
    chk("t1_holdoff_state", {29'd0, st[2:0]}, 32'd5);
    chk("t1_count", {16'd0, cnt0}, 32'd1);
    repeat (8) tick();
    sensor[0] = 1'b0;
    repeat (110) tick();
    chk("t1_rearmed", {29'd0, st[2:0]}, 32'd2);
    chk("t1_n_ev0", n_ev0, 32'd1);
    chk("t1_n_ev1", n_ev1, 32'd0);

    // 2: seven-cycle glitch must not qualify
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("t2_clear", {16'd0, cnt0}, 32'd0);
    sensor[0] = 1'b1;
    repeat (7) tick();
    sensor[0] = 1'b0;
    repeat (6) tick();
    chk("t2_no_event", n_ev0, 32'd1);
    chk("t2_count", {16'd0, cnt0}, 32'd0);
    chk("t2_back_armed", {29'd0, st[2:0]}, 32'd2);

    // 3: hold-off swallows the t=50 edge
    t_first = -1;
    t_second = -1;
    base = n_ev0;
    for (int t = 0; t < 230; t++) begin
      sensor[0] = (t < 12) || (t >= 50 && t < 62) || (t >= 200 && t < 212);
      tick();
      if (ev0) begin
        if (t_first < 0) t_first = t + 1;
        else if (t_second < 0) t_second = t + 1;
      end
    end
    sensor[0] = 1'b0;
    chk("t3_events", n_ev0 - base, 32'd2);
    chk("t3_first_time", t_first, 32'd10);
    chk("t3_second_time", t_second, 32'd210);
    chk("t3_count", {16'd0, cnt0}, 32'd2);

    // 4: level already high when armed
    en = 1'b0;
    tick();
    tick();
    chk("t4_disarmed", {26'd0, st}, 32'd0);
    sensor[1] = 1'b1;
    repeat (4) tick();
    en = 1'b1;
    repeat (30) tick();
    chk("t4_wait_low", {29'd0, st[5:3]}, 32'd1);
    chk("t4_no_event", n_ev1, 32'd0);
    sensor[1] = 1'b0;
    repeat (5) tick();
    chk("t4_armed", {29'd0, st[5:3]}, 32'd2);
    sensor[1] = 1'b1;
    repeat (9) tick();
    chk("t4_not_yet", {31'd0, ev1}, 32'd0);
    tick();
    chk("t4_pulse", {31'd0, ev1}, 32'd1);
    tick();
    sensor[1] = 1'b0;
    chk("t4_n_ev1", n_ev1, 32'd1);
    chk("t4_count", {16'd0, cnt1}, 32'd1);

    // 5: simultaneous edges, clear coinciding with FIRE
    repeat (110) tick();
    chk("t5_both_armed", {26'd0, st}, 32'd18);
    sensor = 2'b11;
    repeat (9) tick();
    chk("t5_not_yet", {30'd0, ev1, ev0}, 32'd0);
    tick();
    chk("t5_same_cycle", {30'd0, ev1, ev0}, 32'd3);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    sensor = 2'b00;
    chk("t5_clear_wins", {cnt1, cnt0}, 32'd0);

    // 6a: saturation with the fast filter path
    for (int e = 0; e < 5; e++) begin
      s_sensor[0] = 1'b1;
      tick();
      tick();
      s_sensor[0] = 1'b0;
      tick();
      if (e == 0) chk("t6_fast_path", {31'd0, s_ev0}, 32'd1);
      repeat (7) tick();
    end
    chk("t6_n_events", s_n_ev0, 32'd5);
    chk("t6_saturate", {30'd0, s_cnt0}, 32'd3);

    // enable dropped during FIRE: pulse and count complete, then disarm
    s_sensor[1] = 1'b1;
    tick();
    tick();
    s_sensor[1] = 1'b0;
    tick();
    chk("t6_fire_ch1", {31'd0, s_ev1}, 32'd1);
    s_en = 1'b0;
    tick();
    chk("t6_fire_disarm", {29'd0, s_st[5:3]}, 32'd0);
    chk("t6_fire_count", {30'd0, s_cnt1}, 32'd1);

    // 6b: asynchronous reset with ch0 in FIRE and ch1 in FILTER
    repeat (60) tick();
    chk("t6_armed", {26'd0, st}, 32'd18);
    sensor[0] = 1'b1;
    repeat (3) tick();
    sensor[1] = 1'b1;
    repeat (7) tick();
    chk("t6_pre_reset_ev", {30'd0, ev1, ev0}, 32'd1);
    chk("t6_pre_reset_st", {26'd0, st}, 32'd28);
    #1 reset = 1'b1;
    #1;
    chk("t6_async_ev", {30'd0, ev1, ev0}, 32'd0);
    chk("t6_async_st", {20'd0, s_st, st}, 32'd0);
    chk("t6_async_cnt", {28'd0, s_cnt1, s_cnt0}, 32'd0);
    sensor = 2'b00;
    tick();
    reset = 1'b0;
    tick();
    chk("no_double_pulse", dbl, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
